uart_8n1_transmitter: RTL and testbench



---
 rtl/uart_8n1_transmitter_if.sv | 22 ++
 rtl/uart_8n1_transmitter.sv | 150 +++++++++++++++
 tb/tb_uart_8n1_transmitter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_8n1_transmitter_if.sv
// Host-side write/busy handshake of the 8N1 UART transmitter.
// The host drives data and write; the transmitter answers with busy and overrun.
interface uart_8n1_transmitter_if;
    logic [7:0] send_data;
    logic       send_write;
    logic       send_busy;
    logic       send_overrun;

    modport master (
        output send_data,
        output send_write,
        input  send_busy,
        input  send_overrun
    );

    modport slave (
        input  send_data,
        input  send_write,
        output send_busy,
        output send_overrun
    );
endinterface

// File: rtl/uart_8n1_transmitter.sv
// 8N1 UART transmitter on a 16x baud clock: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Optional one-entry holding register for gapless frames: define UART_8N1_TX_HOLD_EN.
module uart_8n1_transmitter #(
    parameter int STOP_BITS = 1
) (
    input  logic                         clk_baud_16x,
    input  logic                         reset_n,
    uart_8n1_transmitter_if.slave        send,
    output logic                         tx
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_8n1_transmitter: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

    state_t     state;
    logic [3:0] tick;
    logic [2:0] bit_idx;
    logic [0:0] stop_cnt;
    logic [7:0] shifter;

    logic       accept;
    logic       reject;
    logic       bit_end;
    logic       frame_end;
    logic       start_frame;
    logic [7:0] start_byte;
    logic       active_next;
    logic       busy_next;

    assign accept    = send.send_write & ~send.send_busy;
    assign reject    = send.send_write &  send.send_busy;
    assign bit_end   = (tick == 4'd15);
    assign frame_end = (state == STOP) & bit_end & (stop_cnt == STOP_LAST);

`ifdef UART_8N1_TX_HOLD_EN
    logic [7:0] hold_data;
    logic       hold_full;
    logic       load_pending;
    logic       fill_hold;
    logic       hold_full_next;

    // A frame ending with a full holding register restarts at the same edge, so there is no idle gap.
    assign load_pending   = frame_end & hold_full;
    assign fill_hold      = accept & (state != IDLE) & ~frame_end;
    assign start_frame    = load_pending | (accept & ((state == IDLE) | frame_end));
    assign start_byte     = load_pending ? hold_data : send.send_data;
    assign hold_full_next = load_pending ? 1'b0 : (fill_hold ? 1'b1 : hold_full);
    assign active_next    = start_frame | ((state != IDLE) & ~frame_end);
    assign busy_next      = active_next & hold_full_next;

    always_ff @(posedge clk_baud_16x or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            hold_full <= hold_full_next;
            if (fill_hold) begin
                hold_data <= send.send_data;
            end
        end
    end
`else
    assign start_frame = accept;
    assign start_byte  = send.send_data;
    assign active_next = start_frame | ((state != IDLE) & ~frame_end);
    assign busy_next   = active_next;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
    always_ff @(posedge clk_baud_16x or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: tx sits in the async reset branch so the line returns to idle the moment reset_n falls.
            state             <= IDLE;
            tick              <= 4'd0;
            bit_idx           <= 3'd0;
            stop_cnt          <= 1'b0;
            shifter           <= 8'h00;
            tx                <= 1'b1;
            send.send_busy    <= 1'b0;
            send.send_overrun <= 1'b0;
        end else begin
            send.send_overrun <= reject;
            send.send_busy    <= busy_next;

            if (start_frame) begin
                state    <= START;
                shifter  <= start_byte;
                tx       <= 1'b0;
                tick     <= 4'd0;
                bit_idx  <= 3'd0;
                stop_cnt <= 1'b0;
            end else begin
                if (state != IDLE) begin
                    tick <= tick + 4'd1;
                end
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == 3'd7) begin
                                state   <= STOP;
                                tx      <= 1'b1;
                                bit_idx <= 3'd0;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shifter[0];
                                shifter <= shifter >> 1;
                            end
                        end
                    end
                    STOP: begin
                        tx <= 1'b1;
                        if (bit_end) begin
                            if (stop_cnt == STOP_LAST) begin
                                state    <= IDLE;
                                stop_cnt <= 1'b0;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_8n1_transmitter.sv
// Self-checking bench for uart_8n1_transmitter; expected line levels come from a frame-offset model.
// Covers STOP_BITS=1 and 2 instances; the holding-register scenario runs when UART_8N1_TX_HOLD_EN is defined.
module tb_uart_8n1_transmitter;

    logic clk_baud_16x = 1'b0;
    logic reset_n;
    logic tx1;
    logic tx2;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_8n1_transmitter_if bus1 ();
    uart_8n1_transmitter_if bus2 ();

    uart_8n1_transmitter #(.STOP_BITS(1)) dut1 (
        .clk_baud_16x (clk_baud_16x),
        .reset_n      (reset_n),
        .send         (bus1),
        .tx           (tx1)
    );

    uart_8n1_transmitter #(.STOP_BITS(2)) dut2 (
        .clk_baud_16x (clk_baud_16x),
        .reset_n      (reset_n),
        .send         (bus2),
        .tx           (tx2)
    );

    always #5 clk_baud_16x = ~clk_baud_16x;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    // Line level at a given cycle offset from the accepting edge: 16 cycles of start,
    // 16 per data bit LSB first, then idle/stop level 1. Negative offsets are idle.
    function automatic logic model_tx(input logic [7:0] d, input int off);
        if (off < 0)   return 1'b1;
        if (off < 16)  return 1'b0;
        if (off < 144) return d[(off - 16) / 16];
        return 1'b1;
    endfunction

    task automatic drive(input int sel, input logic w, input logic [7:0] d);
        if (sel == 1) begin
            bus1.send_write = w;
            bus1.send_data  = d;
        end else begin
            bus2.send_write = w;
            bus2.send_data  = d;
        end
    endtask

    task automatic sample(input int sel, output logic t, output logic b, output logic o);
        if (sel == 1) begin
            t = tx1; b = bus1.send_busy; o = bus1.send_overrun;
        end else begin
            t = tx2; b = bus2.send_busy; o = bus2.send_overrun;
        end
    endtask

    // Pulse a write for one edge; returns at the negedge of the accepting cycle with data scrambled.
    task automatic accept_write(input int sel, input logic [7:0] d);
        @(negedge clk_baud_16x);
        drive(sel, 1'b1, d);
        @(negedge clk_baud_16x);
        drive(sel, 1'b0, 8'($urandom));
    endtask

    task automatic check_frame(input int sel, input logic [7:0] d, input int sb, input string tag);
        int   f;
        logic t, b, o;
        f = 16 * (9 + sb);
        for (int off = 0; off < f + 3; off++) begin
            if (off > 0) @(negedge clk_baud_16x);
            sample(sel, t, b, o);
            n_checks++;
            if (t !== model_tx(d, off)) $display("FAIL %s tx at N+%0d: got %b expected %b", tag, off, t, model_tx(d, off));
            else n_pass++;
            n_checks++;
            if (b !== (off < f)) $display("FAIL %s busy at N+%0d: got %b expected %b", tag, off, b, off < f);
            else n_pass++;
            n_checks++;
            if (o !== 1'b0) $display("FAIL %s overrun at N+%0d: got %b expected 0", tag, off, o);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic t, b, o;
        reset_n = 1'b0;
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk_baud_16x);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int sel = 1; sel <= 2; sel++) begin
                sample(sel, t, b, o);
                n_checks++;
                if ({t, b, o} !== 3'b100) $display("FAIL reset_idle dut%0d cycle %0d: got tx/busy/ovr %b expected 100", sel, i, {t, b, o});
                else n_pass++;
            end
            @(negedge clk_baud_16x);
        end
    endtask

    task automatic test_basic_frame();
        accept_write(1, 8'h56);
        check_frame(1, 8'h56, 1, "frame_56");
    endtask

    task automatic test_stop_bits2();
        accept_write(2, 8'hFE);
        check_frame(2, 8'hFE, 2, "stop2_FE");
    endtask

    task automatic test_random_frames();
        int         sel;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            sel = 1 + $urandom_range(0, 1);
            d   = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk_baud_16x);
            accept_write(sel, d);
            check_frame(sel, d, sel, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic t, b, o;
        accept_write(1, 8'hAB);
        repeat (49) @(negedge clk_baud_16x);
        sample(1, t, b, o);
        n_checks++;
        if ({t, b} !== {model_tx(8'hAB, 49), 1'b1}) $display("FAIL pre_reset tx/busy: got %b expected %b1", {t, b}, model_tx(8'hAB, 49));
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        sample(1, t, b, o);
        n_checks++;
        if ({t, b, o} !== 3'b100) $display("FAIL async_reset tx/busy/ovr: got %b expected 100", {t, b, o});
        else n_pass++;
        repeat (3) @(negedge clk_baud_16x);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_baud_16x);
            sample(1, t, b, o);
            n_checks++;
            if ({t, b, o} !== 3'b100) $display("FAIL post_reset_idle cycle %0d: got tx/busy/ovr %b expected 100", i, {t, b, o});
            else n_pass++;
        end
    endtask

`ifndef UART_8N1_TX_HOLD_EN
    task automatic test_held_write();
        logic t, b, o;
        logic exp_t, exp_b, exp_o;
        @(negedge clk_baud_16x);
        drive(1, 1'b1, 8'h77);
        for (int off = 0; off < 330; off++) begin
            @(negedge clk_baud_16x);
            sample(1, t, b, o);
            exp_t = (off < 161) ? model_tx(8'h77, off) : model_tx(8'h77, off - 161);
            exp_b = (off < 160) || (off >= 161 && off < 321);
            exp_o = (off >= 1 && off <= 160) || (off >= 162 && off <= 199);
            n_checks++;
            if ({t, b, o} !== {exp_t, exp_b, exp_o}) $display("FAIL held_write at N+%0d: got tx/busy/ovr %b expected %b", off, {t, b, o}, {exp_t, exp_b, exp_o});
            else n_pass++;
            if (off == 199) drive(1, 1'b0, 8'h00);
        end
    endtask
`endif

`ifdef UART_8N1_TX_HOLD_EN
    task automatic test_hold_register();
        logic t, b, o;
        logic exp_t, exp_b, exp_o;
        accept_write(1, 8'hAB);
        for (int off = 0; off < 330; off++) begin
            if (off > 0) @(negedge clk_baud_16x);
            sample(1, t, b, o);
            exp_t = (off < 160) ? model_tx(8'hAB, off) : model_tx(8'hFE, off - 160);
            exp_b = (off >= 20 && off < 160);
            exp_o = (off == 30);
            n_checks++;
            if ({t, b, o} !== {exp_t, exp_b, exp_o}) $display("FAIL hold at N+%0d: got tx/busy/ovr %b expected %b", off, {t, b, o}, {exp_t, exp_b, exp_o});
            else n_pass++;
            if (off == 19) drive(1, 1'b1, 8'hFE);
            if (off == 20) drive(1, 1'b0, 8'($urandom));
            if (off == 29) drive(1, 1'b1, 8'h3C);
            if (off == 30) drive(1, 1'b0, 8'($urandom));
        end
    endtask
`endif

    // Independent receiver: find the falling start edge, sample each bit at its centre.
    task automatic loopback_byte(input logic [7:0] d);
        logic [7:0] got;
        logic       err;
        logic       seen;
        got  = 8'h00;
        err  = 1'b0;
        seen = 1'b0;
        @(negedge clk_baud_16x);
        drive(1, 1'b1, d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_baud_16x);
            if (i == 0) drive(1, 1'b0, 8'($urandom));
            if (tx1 === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL loopback start %02h: got no start bit within 40 cycles, expected one", d);
        else n_pass++;
        if (seen) begin
            for (int off = 1; off < 160; off++) begin
                @(negedge clk_baud_16x);
                if (off == 8 && tx1 !== 1'b0) err = 1'b1;
                if (off >= 24 && off < 144 && (off - 8) % 16 == 0) got[(off - 24) / 16] = tx1;
                if (off == 152 && tx1 !== 1'b1) err = 1'b1;
            end
            n_checks++;
            if (got !== d) $display("FAIL loopback data: got %02h expected %02h", got, d);
            else n_pass++;
            n_checks++;
            if (err !== 1'b0) $display("FAIL loopback framing %02h: got error flag %b expected 0", d, err);
            else n_pass++;
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes_q[$];
        bytes_q = '{8'h00, 8'hFF, 8'h56, 8'hAB};
        bytes_q.push_back(8'($urandom));
        bytes_q.push_back(8'($urandom));
        foreach (bytes_q[i]) loopback_byte(bytes_q[i]);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        test_reset();
        test_basic_frame();
`ifndef UART_8N1_TX_HOLD_EN
        test_held_write();
`endif
        test_reset_mid_frame();
        test_stop_bits2();
`ifdef UART_8N1_TX_HOLD_EN
        test_hold_register();
`endif
        test_random_frames();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
